// File: rtl/mips_mem_dump.sv
// Debug readback engine: walks a word range of data memory through a synchronous
// read port and streams every word MSB-byte-first on a valid/ready byte interface.
module mips_mem_dump #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cur_addr_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [ADDR_WIDTH:0]     remaining_reg;
    logic [1:0]              byte_idx_reg;
    logic [DATA_WIDTH-1:0]   word_reg;
    logic [7:0]              word_bytes [4];
    logic                    handshake;
    logic                    last_byte;
    logic                    more_words;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

    assign handshake  = out_valid && out_ready;
    assign last_byte  = (byte_idx_reg == 2'd0);
    assign more_words = (remaining_reg > REM_ONE);
    assign mem_addr   = mem_addr_reg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (word_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: state_next = S_WAIT;
            S_WAIT: state_next = S_SEND;
            S_SEND: begin
                if (handshake && last_byte) begin
                    state_next = more_words ? S_READ : S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        case (state_reg)
            S_READ: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
            end
            S_WAIT: busy = 1'b1;
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = word_bytes[byte_idx_reg];
                out_last  = (remaining_reg == REM_ONE) && last_byte;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: address/word counters, captured word and byte pointer.
    // mem_addr_reg only moves when a READ is about to happen, so it holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr_reg  <= '0;
            mem_addr_reg  <= '0;
            remaining_reg <= '0;
            byte_idx_reg  <= 2'd0;
            word_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cur_addr_reg  <= start_addr;
                        remaining_reg <= word_count;
                        if (word_count != '0) begin
                            mem_addr_reg <= start_addr;
                        end
                    end
                end
                S_WAIT: begin
                    word_reg     <= mem_rd_data;
                    byte_idx_reg <= 2'd3;
                end
                S_SEND: begin
                    if (handshake) begin
                        if (!last_byte) begin
                            byte_idx_reg <= byte_idx_reg - 2'd1;
                        end else if (more_words) begin
                            remaining_reg <= remaining_reg - REM_ONE;
                            cur_addr_reg  <= cur_addr_reg + ADDR_ONE;
                            mem_addr_reg  <= cur_addr_reg + ADDR_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_dump.sv
// Bench for mips_mem_dump: a memory model, a queue-based stream model checked every
// cycle, and directed dumps with literal expected byte sequences and latencies.
`timescale 1ns/1ps
module tb_mips_mem_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] word_count;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;

    mips_mem_dump #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stream model state
    logic [7:0] exp_bytes [$];
    logic [9:0] exp_addrs [$];
    logic [7:0] obs [$];
    logic [9:0] obs_addr [$];
    bit         active = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    int start_cyc, first_rd_cyc, first_valid_cyc, done_cyc, last_pos;
    int rd_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_bytes.delete();
            exp_addrs.delete();
            active     = 0;
            prev_stall = 0;
        end else begin
            chk("busy", {31'd0, busy}, {31'd0, active && !done});
            if (mem_rd_en) begin
                rd_cnt++;
                obs_addr.push_back(mem_addr);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (exp_addrs.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else chk("mem_addr", {22'd0, mem_addr}, {22'd0, exp_addrs.pop_front()});
            end
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (prev_stall) chk("stall_hold", {24'd0, out_data}, {24'd0, prev_data});
                if (exp_bytes.size() == 0) begin
                    chk("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("out_data", {24'd0, out_data}, {24'd0, exp_bytes[0]});
                    chk("out_last", {31'd0, out_last}, {31'd0, exp_bytes.size() == 1});
                    if (out_ready) begin
                        obs.push_back(out_data);
                        void'(exp_bytes.pop_front());
                        if (out_last) last_pos = obs.size();
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            // A start is taken only while the engine is idle, before DONE is retired below
            if (start && !active) begin
                active          = 1;
                start_cyc       = cyc;
                first_rd_cyc    = -1;
                first_valid_cyc = -1;
                done_cyc        = -1;
                for (int w = 0; w < int'(word_count); w++) begin
                    logic [9:0]  a;
                    logic [31:0] wd;
                    a  = start_addr + w[9:0];
                    wd = mem[a];
                    exp_addrs.push_back(a);
                    for (int b = 3; b >= 0; b--) exp_bytes.push_back(wd[8*b +: 8]);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_expected", {31'd0, active}, 32'd1);
                chk("leftover", exp_bytes.size() + exp_addrs.size(), 32'd0);
                active = 0;
            end
        end
    end

    logic [7:0] lit_a [8] = '{8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h09};
    logic [7:0] lit_w [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h0A};
    logic [7:0] lit_c [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    logic [3:0] bp_pat = 4'b1001;
    bit         bp = 0;

    task automatic start_dump(input logic [9:0] sa, input logic [10:0] wc);
        @(posedge clk); #1;
        obs.delete();
        obs_addr.delete();
        rd_cnt     = 0;
        last_pos   = -1;
        start_addr = sa;
        word_count = wc;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (bp) out_ready = bp_pat[cyc % 4];
    endtask

    task automatic wait_done(input int d0);
        int i;
        for (i = 0; i < 500 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
            if (bp) out_ready = bp_pat[cyc % 4];
        end
        if (done_cnt == d0) chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_stream8(input string nm, input logic [7:0] lit [8]);
        chk({nm, "_len"}, obs.size(), 32'd8);
        for (int i = 0; i < 8 && i < obs.size(); i++) chk(nm, {24'd0, obs[i]}, {24'd0, lit[i]});
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk(nm, {busy, done, mem_rd_en, out_valid, out_last, 27'd0}, 32'd0);
        chk({nm, "_addr"}, {22'd0, mem_addr}, 32'd0);
        chk({nm, "_data"}, {24'd0, out_data}, 32'd0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[0] = 32'd10; mem[1] = 32'd9; mem[2] = 32'd8; mem[3] = 32'd7;
        mem[4] = 32'h11223344; mem[5] = 32'h55667788; mem[6] = 32'h99AABBCC;
        mem[8] = 32'hCAFEF00D;
        mem[1023] = 32'hDEADBEEF;
        rst = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; out_ready = 1'b1;
        #1;
        chk_outputs_zero("reset_state");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic two-word dump
        d0 = done_cnt;
        start_dump(10'd0, 11'd2);
        wait_done(d0);
        chk_stream8("basic_bytes", lit_a);
        chk("basic_last_pos", last_pos, 32'd8);
        chk("basic_rd_cnt", rd_cnt, 32'd2);
        chk("basic_rd_lat", first_rd_cyc - start_cyc, 32'd1);
        chk("basic_valid_lat", first_valid_cyc - start_cyc, 32'd3);
        chk("basic_done_cnt", done_cnt - d0, 32'd1);

        // Backpressure with out_ready cycling 1-0-0-1
        bp = 1;
        d0 = done_cnt;
        start_dump(10'd0, 11'd2);
        wait_done(d0);
        bp = 0; out_ready = 1'b1;
        chk_stream8("bp_bytes", lit_a);
        chk("bp_done_cnt", done_cnt - d0, 32'd1);

        // Address wrap 1023 -> 0
        d0 = done_cnt;
        start_dump(10'd1023, 11'd2);
        wait_done(d0);
        chk_stream8("wrap_bytes", lit_w);
        chk("wrap_addr0", {22'd0, obs_addr[0]}, 32'd1023);
        chk("wrap_addr1", {22'd0, obs_addr[1]}, 32'd0);

        // Zero-length dump
        d0 = done_cnt;
        start_dump(10'd5, 11'd0);
        wait_done(d0);
        repeat (3) @(posedge clk);
        chk("zero_done_lat", done_cyc - start_cyc, 32'd1);
        chk("zero_rd_cnt", rd_cnt, 32'd0);
        chk("zero_bytes", obs.size(), 32'd0);

        // Reset in the middle of the second word of a three-word dump
        start_dump(10'd4, 11'd3);
        for (int i = 0; i < 200 && obs.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_reached", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("async_reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        d0 = done_cnt;
        start_dump(10'd8, 11'd1);
        wait_done(d0);
        chk("post_rst_len", obs.size(), 32'd4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("post_rst_bytes", {24'd0, obs[i]}, {24'd0, lit_c[i]});
        chk("post_rst_addr", {22'd0, obs_addr[0]}, 32'd8);

        // start pulses while busy and during DONE are ignored
        d0 = done_cnt;
        start_dump(10'd0, 11'd2);
        for (int i = 0; i < 200 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 2) begin start_addr = 10'd5; word_count = 11'd1; start = 1'b1; end
            if (done) begin start_addr = 10'd6; word_count = 11'd1; start = 1'b1; end
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk_stream8("ign_bytes", lit_a);
        chk("ign_done_cnt", done_cnt - d0, 32'd1);
        chk("ign_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
